// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn sequencer.
//   state_t    : sequencer FSM states
//   CELL_A..I  : bit index of each cell in a 9-bit board (a = bit 0 ... i = bit 8)
//   WIN_LINES  : the eight winning masks (three rows, three columns, two diagonals)
package ttt_pkg;

    typedef enum logic [2:0] {
        P1_TURN,
        P2_TURN,
        CHECK,
        P1_WON,
        P2_WON,
        DRAW
    } state_t;

    localparam int CELL_A = 0;
    localparam int CELL_B = 1;
    localparam int CELL_C = 2;
    localparam int CELL_D = 3;
    localparam int CELL_E = 4;
    localparam int CELL_F = 5;
    localparam int CELL_G = 6;
    localparam int CELL_H = 7;
    localparam int CELL_I = 8;

    // Board layout:  a b c / d e f / g h i
    // Index 0 is the last element of the concatenation.
    localparam logic [7:0][8:0] WIN_LINES = {
        9'h054,   // c e g diagonal
        9'h111,   // a e i diagonal
        9'h124,   // c f i column
        9'h092,   // b e h column
        9'h049,   // a d g column
        9'h1C0,   // g h i row
        9'h038,   // d e f row
        9'h007    // a b c row
    };

endpackage

// File: rtl/line_check.sv
// Combinational win detector.
//   occ : 9-bit occupancy of one player's board
//   win : 1 when occ covers at least one of the eight winning lines
module line_check
    import ttt_pkg::*;
(
    input  logic [8:0] occ,
    output logic       win
);

    logic [7:0] hit;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            assign hit[gi] = ((occ & WIN_LINES[gi]) == WIN_LINES[gi]);
        end
    endgenerate

    assign win = |hit;

endmodule

// File: rtl/turn_sequencer.sv
// Two-player tic-tac-toe turn sequencer.
//   clk        : system clock, rising edge
//   reset      : asynchronous assert, synchronized release, active-low
//   button     : raw cell buttons (bit 0 = a ... bit 8 = i), active-high
//   new_game   : clear the board, keep scores, swap the starting player
//   board_p1/2 : cells owned by each player
//   p1/p2_turn : whose move it is
//   p1/p2_win, draw : held result of the current game
//   move_count : moves placed in the current game (0..9)
//   p1/p2_score: saturating win counters
//   illegal    : one-cycle pulse when a press is rejected
module turn_sequencer
    import ttt_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8:0]         button,
    input  logic               new_game,
    output logic [8:0]         board_p1,
    output logic [8:0]         board_p2,
    output logic               p1_turn,
    output logic               p2_turn,
    output logic               p1_win,
    output logic               p2_win,
    output logic               draw,
    output logic [3:0]         move_count,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               illegal
);

    // Reset goes low asynchronously through this pair, but comes out of reset
    // only on a clock edge so no flop sees a release near its active edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_reg <= 2'b00;
        else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end

    assign rst_n = rst_sync_reg[1];

    // Button synchronizer chain plus edge history.
    logic [SYNC_STAGES-1:0][8:0] sync_reg;
    logic [8:0]                  prev_reg;
    logic [8:0]                  press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= '0;
        end else begin
            sync_reg[0] <= button;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign press = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    // More than one bit set: clearing the lowest set bit leaves something.
    logic multi_press;
    logic occupied;
    assign multi_press = |(press & (press - 9'd1));
    assign occupied    = |(press & (board_p1 | board_p2));

    // Single win detector, always looking at the player who just moved.
    logic       mover_reg;     // 0 = player 1, 1 = player 2
    logic       starter_reg;   // 0 = player 1 opens the game
    logic [8:0] mover_board;
    logic       mover_win;

    assign mover_board = mover_reg ? board_p2 : board_p1;

    line_check u_line_check (
        .occ (mover_board),
        .win (mover_win)
    );

    state_t state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= P1_TURN;
            starter_reg <= 1'b0;
            mover_reg   <= 1'b0;
            board_p1    <= '0;
            board_p2    <= '0;
            move_count  <= '0;
            p1_score    <= '0;
            p2_score    <= '0;
            p1_turn     <= 1'b1;
            p2_turn     <= 1'b0;
            p1_win      <= 1'b0;
            p2_win      <= 1'b0;
            draw        <= 1'b0;
            illegal     <= 1'b0;
        end else if (new_game) begin
            // A coincident press is simply dropped here.
            board_p1    <= '0;
            board_p2    <= '0;
            move_count  <= '0;
            p1_win      <= 1'b0;
            p2_win      <= 1'b0;
            draw        <= 1'b0;
            illegal     <= 1'b0;
            starter_reg <= ~starter_reg;
            state_reg   <= starter_reg ? P1_TURN : P2_TURN;
            p1_turn     <= starter_reg;
            p2_turn     <= ~starter_reg;
        end else begin
            illegal <= 1'b0;
            case (state_reg)
                P1_TURN, P2_TURN: begin
                    if (press != 9'd0) begin
                        if (multi_press || occupied) begin
                            illegal <= 1'b1;
                        end else begin
                            if (state_reg == P1_TURN) board_p1 <= board_p1 | press;
                            else                      board_p2 <= board_p2 | press;
                            move_count <= move_count + 4'd1;
                            mover_reg  <= (state_reg == P2_TURN);
                            state_reg  <= CHECK;
                            p1_turn    <= 1'b0;
                            p2_turn    <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    // Win is tested before the full-board case so a ninth-move
                    // win is never reported as a draw.
                    if (mover_win) begin
                        if (mover_reg) begin
                            state_reg <= P2_WON;
                            p2_win    <= 1'b1;
                            if (p2_score != '1) p2_score <= p2_score + 1'b1;
                        end else begin
                            state_reg <= P1_WON;
                            p1_win    <= 1'b1;
                            if (p1_score != '1) p1_score <= p1_score + 1'b1;
                        end
                    end else if (move_count == 4'd9) begin
                        state_reg <= DRAW;
                        draw      <= 1'b1;
                    end else if (mover_reg) begin
                        state_reg <= P1_TURN;
                        p1_turn   <= 1'b1;
                    end else begin
                        state_reg <= P2_TURN;
                        p2_turn   <= 1'b1;
                    end
                end
                default: begin
                    // Terminal states hold until new_game; presses are ignored.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;
    import ttt_pkg::*;

    logic       clk;
    logic       reset;
    logic [8:0] button;
    logic       new_game;
    logic [8:0] board_p1, board_p2;
    logic       p1_turn, p2_turn, p1_win, p2_win, draw;
    logic [3:0] move_count;
    logic [3:0] p1_score, p2_score;
    logic       illegal;

    turn_sequencer #(.SYNC_STAGES(2), .SCORE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .new_game   (new_game),
        .board_p1   (board_p1),
        .board_p2   (board_p2),
        .p1_turn    (p1_turn),
        .p2_turn    (p2_turn),
        .p1_win     (p1_win),
        .p2_win     (p2_win),
        .draw       (draw),
        .move_count (move_count),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int illegal_cnt = 0;

    // illegal is a registered one-cycle pulse: count it mid-cycle.
    always @(negedge clk) if (illegal === 1'b1) illegal_cnt++;

    typedef struct {
        logic       ng;      // 1: pulse new_game instead of pressing
        logic [8:0] btn;
        logic [8:0] e_p1;
        logic [8:0] e_p2;
        logic       e_t1, e_t2, e_w1, e_w2, e_dr;
        logic [3:0] e_mc;
        logic [3:0] e_s1, e_s2;
        int         e_ill;   // expected illegal pulses for this step
    } vec_t;

    vec_t vecs[$];

    localparam logic [8:0] A = 9'(1) << CELL_A;
    localparam logic [8:0] B = 9'(1) << CELL_B;
    localparam logic [8:0] C = 9'(1) << CELL_C;
    localparam logic [8:0] D = 9'(1) << CELL_D;
    localparam logic [8:0] E = 9'(1) << CELL_E;
    localparam logic [8:0] F = 9'(1) << CELL_F;
    localparam logic [8:0] G = 9'(1) << CELL_G;
    localparam logic [8:0] H = 9'(1) << CELL_H;
    localparam logic [8:0] I = 9'(1) << CELL_I;

    task automatic add(input logic ng, input logic [8:0] btn,
                       input logic [8:0] p1, input logic [8:0] p2,
                       input logic t1, input logic t2, input logic w1,
                       input logic w2, input logic dr, input logic [3:0] mc,
                       input logic [3:0] s1, input logic [3:0] s2, input int ill);
        vec_t v;
        v.ng = ng; v.btn = btn; v.e_p1 = p1; v.e_p2 = p2;
        v.e_t1 = t1; v.e_t2 = t2; v.e_w1 = w1; v.e_w2 = w2; v.e_dr = dr;
        v.e_mc = mc; v.e_s1 = s1; v.e_s2 = s2; v.e_ill = ill;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [8:0] mask);
        button = mask;
        repeat (3) tick();
        button = '0;
        repeat (3) tick();
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".board_p1"},   32'(board_p1),   32'(v.e_p1));
        chk({tag, ".board_p2"},   32'(board_p2),   32'(v.e_p2));
        chk({tag, ".p1_turn"},    32'(p1_turn),    32'(v.e_t1));
        chk({tag, ".p2_turn"},    32'(p2_turn),    32'(v.e_t2));
        chk({tag, ".p1_win"},     32'(p1_win),     32'(v.e_w1));
        chk({tag, ".p2_win"},     32'(p2_win),     32'(v.e_w2));
        chk({tag, ".draw"},       32'(draw),       32'(v.e_dr));
        chk({tag, ".move_count"}, 32'(move_count), 32'(v.e_mc));
        chk({tag, ".p1_score"},   32'(p1_score),   32'(v.e_s1));
        chk({tag, ".p2_score"},   32'(p2_score),   32'(v.e_s2));
    endtask

    initial begin
        vec_t rst_v;
        int   ill_before;

        //   ng btn    p1      p2      t1 t2 w1 w2 dr mc s1 s2 ill
        // Game 1: P1 opens, wins on top row
        add(0, A,     9'h001, 9'h000, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, D,     9'h001, 9'h008, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        add(0, B,     9'h003, 9'h008, 0, 1, 0, 0, 0, 3, 0, 0, 0);
        add(0, E,     9'h003, 9'h018, 1, 0, 0, 0, 0, 4, 0, 0, 0);
        add(0, C,     9'h007, 9'h018, 0, 0, 1, 0, 0, 5, 1, 0, 0);
        add(0, I,     9'h007, 9'h018, 0, 0, 1, 0, 0, 5, 1, 0, 0);  // ignored after win
        add(1, 9'h0,  9'h000, 9'h000, 0, 1, 0, 0, 0, 0, 1, 0, 0);  // P2 starts
        // Game 2: occupied cell and double press
        add(0, A,     9'h000, 9'h001, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        add(0, E,     9'h010, 9'h001, 0, 1, 0, 0, 0, 2, 1, 0, 0);
        add(0, E,     9'h010, 9'h001, 0, 1, 0, 0, 0, 2, 1, 0, 1);
        add(0, A | I, 9'h010, 9'h001, 0, 1, 0, 0, 0, 2, 1, 0, 1);
        add(1, 9'h0,  9'h000, 9'h000, 1, 0, 0, 0, 0, 0, 1, 0, 0);  // P1 starts
        // Game 3: draw
        add(0, A,     9'h001, 9'h000, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        add(0, B,     9'h001, 9'h002, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        add(0, C,     9'h005, 9'h002, 0, 1, 0, 0, 0, 3, 1, 0, 0);
        add(0, E,     9'h005, 9'h012, 1, 0, 0, 0, 0, 4, 1, 0, 0);
        add(0, D,     9'h00D, 9'h012, 0, 1, 0, 0, 0, 5, 1, 0, 0);
        add(0, F,     9'h00D, 9'h032, 1, 0, 0, 0, 0, 6, 1, 0, 0);
        add(0, H,     9'h08D, 9'h032, 0, 1, 0, 0, 0, 7, 1, 0, 0);
        add(0, G,     9'h08D, 9'h072, 1, 0, 0, 0, 0, 8, 1, 0, 0);
        add(0, I,     9'h18D, 9'h072, 0, 0, 0, 0, 1, 9, 1, 0, 0);
        add(1, 9'h0,  9'h000, 9'h000, 0, 1, 0, 0, 0, 0, 1, 0, 0);  // P2 starts
        // Game 4: P2 wins on the ninth move
        add(0, B,     9'h000, 9'h002, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        add(0, A,     9'h001, 9'h002, 0, 1, 0, 0, 0, 2, 1, 0, 0);
        add(0, D,     9'h001, 9'h00A, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        add(0, C,     9'h005, 9'h00A, 0, 1, 0, 0, 0, 4, 1, 0, 0);
        add(0, F,     9'h005, 9'h02A, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        add(0, G,     9'h045, 9'h02A, 0, 1, 0, 0, 0, 6, 1, 0, 0);
        add(0, H,     9'h045, 9'h0AA, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        add(0, I,     9'h145, 9'h0AA, 0, 1, 0, 0, 0, 8, 1, 0, 0);
        add(0, E,     9'h145, 9'h0BA, 0, 0, 0, 1, 0, 9, 1, 1, 0);
        add(1, 9'h0,  9'h000, 9'h000, 1, 0, 0, 0, 0, 0, 1, 1, 0);  // P1 starts

        button   = '0;
        new_game = 1'b0;
        reset    = 1'b0;
        repeat (3) tick();

        rst_v = '{ng:0, btn:0, e_p1:0, e_p2:0, e_t1:1, e_t2:0, e_w1:0, e_w2:0,
                  e_dr:0, e_mc:0, e_s1:0, e_s2:0, e_ill:0};
        chk_all("reset", rst_v);
        chk("reset.illegal", 32'(illegal), 32'd0);
        $display("reset state checked");

        reset = 1'b1;
        repeat (3) tick();

        foreach (vecs[k]) begin
            ill_before = illegal_cnt;
            if (vecs[k].ng) pulse_new_game();
            else            press(vecs[k].btn);
            chk_all($sformatf("vec%0d", k), vecs[k]);
            chk($sformatf("vec%0d.illegal_pulses", k), 32'(illegal_cnt - ill_before), 32'(vecs[k].e_ill));
            $display("vec %0d: ng=%0b btn=%03h p1=%03h p2=%03h turn=%0b%0b res=%0b%0b%0b mc=%0d score=%0d/%0d",
                     k, vecs[k].ng, vecs[k].btn, board_p1, board_p2, p1_turn, p2_turn,
                     p1_win, p2_win, draw, move_count, p1_score, p2_score);
        end

        // Held button produces exactly one move.
        button = A;
        repeat (20) tick();
        button = '0;
        repeat (3) tick();
        chk("hold.board_p1",   32'(board_p1),   32'h001);
        chk("hold.move_count", 32'(move_count), 32'd1);
        chk("hold.p2_turn",    32'(p2_turn),    32'd1);
        $display("hold a 20 cycles: p1=%03h mc=%0d", board_p1, move_count);

        // Reset mid-game clears outputs without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", rst_v);
        chk("async_reset.illegal", 32'(illegal), 32'd0);
        $display("async reset mid-game: p1=%03h score=%0d/%0d", board_p1, p1_score, p2_score);
        tick();
        reset = 1'b1;
        repeat (4) tick();

        // new_game wins over a coincident press pulse.
        button = C;
        tick();
        tick();          // press pulse is live until the next edge
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        button   = '0;
        repeat (4) tick();
        chk("ng_vs_press.board_p1",   32'(board_p1),   32'h000);
        chk("ng_vs_press.move_count", 32'(move_count), 32'd0);
        chk("ng_vs_press.p2_turn",    32'(p2_turn),    32'd1);
        $display("new_game with press: p1=%03h mc=%0d p2_turn=%0b", board_p1, move_count, p2_turn);

        // Latency: pulse at t, board at t+1, turn output at t+2.
        button = A;
        tick();
        tick();          // pulse now live
        chk("lat.board_before", 32'(board_p2), 32'h000);
        tick();
        chk("lat.board_t1",     32'(board_p2), 32'h001);
        chk("lat.turn_t1",      32'({p1_turn, p2_turn}), 32'd0);
        tick();
        chk("lat.p1_turn_t2",   32'(p1_turn),  32'd1);
        button = '0;
        repeat (3) tick();
        $display("latency sequence: p2=%03h p1_turn=%0b", board_p2, p1_turn);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
